// File: rtl/gimli_lwc_block_serializer.sv
// Gimli rate-block to word serializer feeding the LWC output buffer.
// Optional: `define GIMLI_LWC_SERIALIZER_ZERO_PAD_EN zeroes pad bytes.
module gimli_lwc_block_serializer #(
  parameter int G_WIDTH       = 32,
  parameter int G_BLOCK_WIDTH = 128,
  localparam int SW = $clog2(G_BLOCK_WIDTH/8) + 1
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic [G_BLOCK_WIDTH-1:0] din_i,
  input  logic [SW-1:0]            din_size_i,
  input  logic                     din_last_i,
  input  logic                     din_valid_i,
  output logic                     din_ready_o,
  output logic [G_WIDTH-1:0]       dout_o,
  output logic                     dout_last_o,
  output logic                     dout_valid_o,
  input  logic                     dout_ready_i
);

  localparam int NB  = G_BLOCK_WIDTH / 8;
  localparam int NW  = G_BLOCK_WIDTH / G_WIDTH;
  localparam int BPW = G_WIDTH / 8;
  localparam int RW  = $clog2(NW + 1);

  typedef enum logic {
    IDLE,
    SEND
  } state_e;

  state_e state_q, state_d;

  logic [G_BLOCK_WIDTH-1:0] blk_q;
  logic [RW-1:0]            rem_q;
  logic                     last_q;
  logic [SW-1:0]            sz;
  logic [SW:0]              sz_up;
  logic [RW-1:0]            rem_n;
  logic                     fin;
  logic                     acc;
  logic                     dhs;
  logic                     load;
  logic [G_WIDTH-1:0]       word;

`ifdef GIMLI_LWC_SERIALIZER_ZERO_PAD_EN
  logic [SW-1:0] fb_q;
  logic [SW-1:0] fb_n;
`endif

  always_comb begin
    sz = din_size_i;
    if (din_size_i > SW'(NB)) begin
      sz = SW'(NB);
    end
  end

  // Words needed for the block: ceil(size / bytes-per-word).
  assign sz_up = {1'b0, sz} + (SW+1)'(BPW - 1);
  assign rem_n = RW'(sz_up / (SW+1)'(BPW));

`ifdef GIMLI_LWC_SERIALIZER_ZERO_PAD_EN
  assign fb_n = sz % SW'(BPW);
`endif

  assign fin  = (rem_q == RW'(1));
  assign acc  = din_valid_i & din_ready_o;
  assign dhs  = dout_valid_o & dout_ready_i;
  assign load = acc & (sz != '0);

  always_comb begin
    word = blk_q[G_WIDTH-1:0];
`ifdef GIMLI_LWC_SERIALIZER_ZERO_PAD_EN
    // fb_q==0 means the final word is completely filled.
    for (int j = 0; j < BPW; j++) begin
      if (fin && (fb_q != '0) && (SW'(j) >= fb_q)) begin
        word[8*j +: 8] = 8'h00;
      end
    end
`endif
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (load) begin
          state_d = SEND;
        end
      end
      SEND: begin
        if (dhs && fin) begin
          state_d = load ? SEND : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    din_ready_o  = 1'b0;
    dout_valid_o = 1'b0;
    dout_last_o  = 1'b0;
    dout_o       = '0;
    unique case (state_q)
      IDLE: begin
        din_ready_o = 1'b1;
      end
      SEND: begin
        din_ready_o  = fin & dout_ready_i;
        dout_valid_o = 1'b1;
        dout_last_o  = last_q & fin;
        dout_o       = word;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      blk_q  <= '0;
      rem_q  <= '0;
      last_q <= 1'b0;
`ifdef GIMLI_LWC_SERIALIZER_ZERO_PAD_EN
      fb_q   <= '0;
`endif
    end else if (load) begin
      blk_q  <= din_i;
      rem_q  <= rem_n;
      last_q <= din_last_i;
`ifdef GIMLI_LWC_SERIALIZER_ZERO_PAD_EN
      fb_q   <= fb_n;
`endif
    end else if (dhs && !fin) begin
      blk_q  <= blk_q >> G_WIDTH;
      rem_q  <= rem_q - RW'(1);
    end
  end

endmodule

// File: tb/tb_gimli_lwc_block_serializer.sv
// Self-checking bench for gimli_lwc_block_serializer.
// Word-queue reference model; honours GIMLI_LWC_SERIALIZER_ZERO_PAD_EN.
module tb_gimli_lwc_block_serializer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] din;
  logic [4:0]   din_size;
  logic         din_last;
  logic         din_valid;
  logic         din_ready;
  logic [31:0]  dout;
  logic         dout_last;
  logic         dout_valid;
  logic         dout_ready;

  typedef struct {
    logic [31:0] d;
    logic        l;
  } wexp_t;

  wexp_t q[$];
  int    checks   = 0;
  int    failures = 0;
  bit    acc_seen;
  bit    rnd_ready = 1'b0;

  gimli_lwc_block_serializer dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .din_i       (din),
    .din_size_i  (din_size),
    .din_last_i  (din_last),
    .din_valid_i (din_valid),
    .din_ready_o (din_ready),
    .dout_o      (dout),
    .dout_last_o (dout_last),
    .dout_valid_o(dout_valid),
    .dout_ready_i(dout_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected words of one accepted block, straight from the block rules.
  task automatic push_block(input logic [127:0] d, input int size,
                            input logic l);
    int sz;
    int n;
    logic [31:0] w;
    sz = (size > 16) ? 16 : size;
    n  = (sz + 3) / 4;
    for (int k = 0; k < n; k++) begin
      w = d[32*k +: 32];
`ifdef GIMLI_LWC_SERIALIZER_ZERO_PAD_EN
      if (k == n - 1 && (sz % 4) != 0) begin
        for (int b = sz % 4; b < 4; b++) w[8*b +: 8] = 8'h00;
      end
`endif
      q.push_back('{w, l && (k == n - 1)});
    end
  endtask

  task automatic cyc();
    bit er;
    bit hs;
    bit acc;
    if (rnd_ready) dout_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    acc_seen = 1'b0;
    if (!rst_n) begin
      q.delete();
      chk("rst_dout_valid", 32'(dout_valid), 32'd0);
      chk("rst_dout_last", 32'(dout_last), 32'd0);
      chk("rst_dout", dout, 32'd0);
    end else begin
      er = (q.size() == 0) || (q.size() == 1 && dout_ready);
      chk("dout_valid", 32'(dout_valid), 32'(q.size() != 0));
      chk("din_ready", 32'(din_ready), 32'(er));
      if (q.size() != 0) begin
        chk("dout", dout, q[0].d);
        chk("dout_last", 32'(dout_last), 32'(q[0].l));
      end
      hs  = (q.size() != 0) && dout_ready;
      acc = din_valid && er;
      if (hs) void'(q.pop_front());
      if (acc) push_block(din, int'(din_size), din_last);
      acc_seen = acc;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [127:0] d, input logic [4:0] s,
                      input logic l);
    int n;
    din       = d;
    din_size  = s;
    din_last  = l;
    din_valid = 1'b1;
    n = 0;
    do begin
      cyc();
      n++;
    end while (!acc_seen && n < 100);
    chk("din_accept", 32'(acc_seen), 32'd1);
    din_valid = 1'b0;
    din       = {4{$urandom}};
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 300) begin
      cyc();
      n++;
    end
    chk("drain_left", 32'(q.size()), 32'd0);
    cyc();
  endtask

  initial begin
    logic [127:0] ramp;
    logic [3:0]   pat;
    int           n;
    for (int i = 0; i < 16; i++) ramp[8*i +: 8] = 8'(i);
    pat        = 4'b1001;
    rst_n      = 1'b0;
    din        = {4{32'hDEADBEEF}};
    din_size   = 5'd16;
    din_last   = 1'b1;
    din_valid  = 1'b1;
    dout_ready = 1'b1;
    #1;
    repeat (3) cyc();
    rst_n     = 1'b1;
    din_valid = 1'b0;
    cyc();

    send(ramp, 5'd16, 1'b1);
    drain();

    send({16{8'hAA}}, 5'd6, 1'b1);
    drain();

    send(ramp, 5'd16, 1'b0);
    send(~ramp, 5'd16, 1'b1);
    drain();

    send(ramp, 5'd16, 1'b1);
    n = 0;
    while (q.size() != 0 && n < 100) begin
      dout_ready = pat[n % 4];
      cyc();
      n++;
    end
    chk("bp_drain_left", 32'(q.size()), 32'd0);
    dout_ready = 1'b1;
    cyc();

    send(ramp, 5'd0, 1'b1);
    cyc();
    cyc();

    send(ramp, 5'd27, 1'b1);
    drain();

    send(ramp, 5'd16, 1'b1);
    cyc();
    cyc();
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(dout_valid), 32'd0);
    q.delete();
    cyc();
    rst_n = 1'b1;
    repeat (3) cyc();

    rnd_ready = 1'b1;
    repeat (60) begin
      send({$urandom, $urandom, $urandom, $urandom},
           5'($urandom_range(0, 20)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) drain();
    end
    rnd_ready  = 1'b0;
    dout_ready = 1'b1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
